// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch-prediction slice: default sizing for the
// resolve queue, the pointer-width helper and the 1-bit direction encoding
// that the predictor and the resolve queue agree on.
//
// Optional feature macro used by this slice: BRQ_STATS_EN (see
// branch_resolve_queue.sv).
// -----------------------------------------------------------------------------
package bp_pkg;

    // Default maximum number of in-flight branches (power of two, >= 2).
    localparam int DEPTH_DEF  = 4;
    // Default width of the statistics counters.
    localparam int STAT_W_DEF = 16;

    // Branch direction encoding, shared with the predictor.
    localparam logic DIR_NT = 1'b0;
    localparam logic DIR_T  = 1'b1;

    // Pointer width for a ring of the given depth. Clamped to at least one
    // bit so a degenerate depth still elaborates.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bp_ring_fifo.sv
// -----------------------------------------------------------------------------
// bp_ring_fifo
// 1-bit-wide ring buffer with push, pop and flush. Occupancy, full and empty
// are registered and updated at the same edge as the pointers.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   push       in   write push_data at the tail (ignored when full unless a
//                   pop happens on the same edge, ignored during flush)
//   push_data  in   bit to write
//   pop        in   remove the head entry (ignored when empty)
//   flush      in   discard every entry; wins over push and pop
//   head       out  oldest entry (only meaningful when empty = 0)
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module bp_ring_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      push_data,
    input  logic                      pop,
    input  logic                      flush,
    output logic                      head,
    output logic                      full,
    output logic                      empty,
    output logic [ptr_w(DEPTH):0]     count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot on the same edge, so push into a full ring is
    // accepted when it is paired with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);

    assign head = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                // Dropping everything is just catching the reader up to
                // the writer; storage contents become don't-care.
                rd_ptr <= wr_ptr;
            end else begin
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (do_push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
// Sits downstream of the 2-bit saturating-counter predictor. Every registered
// prediction becomes an in-flight branch, kept in program order. When execute
// resolves the oldest branch, the entry is popped, the predictor is trained
// (result/taken) and a mispredict is flagged if the recorded prediction
// disagrees with the actual direction. A mispredict flushes every younger
// entry, since those were fetched down the wrong path.
//
// Optional feature: define BRQ_STATS_EN to add saturating resolve and
// mispredict counters (resolved_cnt, mispredict_cnt, STAT_W bits each).
//
// Handshake: there is no back-pressure. request and resolve_valid are plain
// strobes acted on at the edge where they are high; a capture while full (with
// no pop) is dropped and latched in overflow, a resolve while empty is ignored
// and latched in underflow.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous, active-high reset
//   request        in   same request strobe the predictor receives
//   prediction     in   predictor output, valid the cycle after request
//   resolve_valid  in   execute resolved the oldest branch this cycle
//   resolve_taken  in   actual direction, qualified by resolve_valid
//   result         out  training strobe to predictor, one-cycle pulse
//   taken          out  training direction, holds when result = 0
//   mispredict     out  one-cycle pulse: resolved direction != prediction
//   full           out  count == DEPTH
//   empty          out  count == 0
//   count          out  occupancy
//   overflow       out  sticky: a capture was dropped because of full
//   underflow      out  sticky: resolve_valid arrived while empty
//   resolved_cnt   out  (BRQ_STATS_EN) accepted resolves, saturating
//   mispredict_cnt out  (BRQ_STATS_EN) mispredicts, saturating
// -----------------------------------------------------------------------------
module branch_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int STAT_W = STAT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    request,
    input  logic                    prediction,
    input  logic                    resolve_valid,
    input  logic                    resolve_taken,
    output logic                    result,
    output logic                    taken,
    output logic                    mispredict,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
`ifdef BRQ_STATS_EN
    ,
    output logic [STAT_W-1:0]       resolved_cnt,
    output logic [STAT_W-1:0]       mispredict_cnt
`endif
);

    logic req_d;
    logic head;
    logic pop_ok;
    logic mis_now;
    logic push_drop;

    // The predictor answers one cycle after request, so the delayed strobe
    // marks the cycle in which prediction is valid.
    assign pop_ok    = resolve_valid && !empty;
    assign mis_now   = pop_ok && (head != resolve_taken);
    // Full with no pop and no flush: the capture has nowhere to go.
    assign push_drop = req_d && !mis_now && full && !pop_ok;

    bp_ring_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_d),
        .push_data (prediction),
        .pop       (pop_ok),
        .flush     (mis_now),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            req_d      <= 1'b0;
            result     <= 1'b0;
            taken      <= DIR_NT;
            mispredict <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            // A request seen on the mispredict edge belongs to the wrong
            // path too, so it never reaches the capture stage.
            req_d      <= mis_now ? 1'b0 : request;
            result     <= pop_ok;
            mispredict <= mis_now;
            if (pop_ok) begin
                taken <= resolve_taken;
            end
            if (push_drop) begin
                overflow <= 1'b1;
            end
            if (resolve_valid && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef BRQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            resolved_cnt   <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (pop_ok && (resolved_cnt != '1)) begin
                resolved_cnt <= resolved_cnt + STAT_W'(1);
            end
            if (mis_now && (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Downstream of the 2-bit saturating-counter predictor: records each registered prediction as an in-flight branch in program order.
- On branch resolution from execute it pops the oldest entry, drives the predictor's training inputs (result/taken) and flags mispredicts.
- A mispredict flushes all younger in-flight entries, which are wrong-path.

Parameters:
- DEPTH, 4, maximum in-flight branches; power of two, >= 2.
- STAT_W, 16, width of the statistics counters (used only with BRQ_STATS_EN).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- request  input  1  same request strobe the predictor receives.
- prediction  input  1  predictor output, valid the cycle after request.
- resolve_valid  input  1  execute resolved the oldest branch this cycle.
- resolve_taken  input  1  actual direction, qualified by resolve_valid.
- result  output  1  training strobe to predictor, one-cycle pulse.
- taken  output  1  training direction to predictor.
- mispredict  output  1  one-cycle pulse: resolved direction != recorded prediction.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  occupancy.
- overflow  output  1  sticky: a capture was dropped because the queue was full.
- underflow  output  1  sticky: resolve_valid arrived while empty.

Behaviour:
- Reset (sync, rst=1 at edge): pointers, count, req_d, result, taken, mispredict, overflow, underflow, stats all 0; empty=1, full=0. Reset mid-operation discards all entries and any pending capture.
- Capture: request is registered into req_d. At an edge with req_d=1 the block pushes the prediction input. Request in cycle N produces an entry visible in cycle N+2.
- Resolve: at an edge with resolve_valid=1 and not empty:
  - pop head;
  - result<=1, taken<=resolve_taken;
  - mispredict<=(head != resolve_taken).
  - All three are registered and high in cycle M+1 only; result/mispredict are 0 otherwise.
  - taken holds its last value when result=0.
- Mispredict flush: on the same edge that pops a mispredicted entry, all remaining entries are cleared (count<=0, rd_ptr<=wr_ptr). Any simultaneous push from req_d is discarded, and req_d is cleared. Requests from cycle M+1 onward are accepted normally.
- Simultaneous push and pop, no mispredict: both occur; count unchanged. This is legal even when full.
- Push when full without pop: dropped, overflow<=1, no state change.
- Resolve when empty: ignored (result stays 0), underflow<=1.
- Sticky flags clear only on rst.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is exact from 0 to DEPTH.
- full/empty/count are registered state, updated at the edge.

Optional Feature:
- Macro BRQ_STATS_EN.
- When defined:
  - add outputs resolved_cnt and mispredict_cnt, each STAT_W bits;
  - resolved_cnt increments on every accepted resolve; mispredict_cnt increments on every mispredict;
  - both saturate at all-ones and clear on rst.
- When undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package bp_pkg holds:
  - the DEPTH and STAT_W defaults;
  - a localparam function for pointer width;
  - the 1-bit direction encoding constants DIR_NT=0, DIR_T=1, shared with the predictor.
- Sub-module bp_ring_fifo: 1-bit-wide ring buffer with push/pop/flush, full/empty/count. branch_resolve_queue adds req_d capture, compare/mispredict, training outputs, sticky flags and stats.

Test Plan:
- Reset then idle -> empty=1, count=0, result=0, mispredict=0, overflow=0.
- request in cycle 1 with prediction=1 in cycle 2; resolve_valid=1, resolve_taken=1 in cycle 4 -> cycle 5: result=1, taken=1, mispredict=0; count back to 0.
- Three captures with predictions 1,1,0; resolve the first with taken=0 -> mispredict=1 next cycle, count=0 (two younger entries flushed); a concurrent req_d push is also dropped.
- DEPTH=4: five captures without resolve -> full=1 after the 4th, overflow=1 after the 5th, count=4. Then push plus resolve (correct) in the same cycle -> count stays 4.
- resolve_valid while empty -> underflow=1, result=0. Assert rst mid-queue with count=3 -> next cycle count=0, flags cleared.
- BRQ_STATS_EN, STAT_W=2: 5 correct resolves -> resolved_cnt=3 (saturated), mispredict_cnt=0.
